// File: rtl/vga_frame_buffer.sv
// True dual-port pixel frame buffer with a hardware clear engine.
// Port A wins same-address write collisions; port writes are dropped while a clear runs.
module vga_frame_buffer #(
  parameter int unsigned DATA_W   = 3,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DEPTH    = 131072,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              dvalid_a,
  input  logic              we_b,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              dvalid_b,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_color,
  output logic              busy,
  output logic              clear_done
);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_color;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_dout_a;
  logic [DATA_W-1:0] r_dout_b;
  logic              r_dvalid_a;
  logic              r_dvalid_b;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_in_a;
  logic w_in_b;
  logic w_we_a;
  logic w_we_b;
  logic w_clr_we;

  assign w_in_a   = ({1'b0, addr_a} < DepthW);
  assign w_in_b   = ({1'b0, addr_b} < DepthW);
  assign w_we_a   = we_a & w_in_a & ~r_busy;
  assign w_we_b   = we_b & w_in_b & ~r_busy & ~(w_we_a & (addr_a == addr_b));
  // Reset on the same edge suppresses the clear write, leaving a clean partial fill.
  assign w_clr_we = (r_state == StClear) & ~reset;

  // Storage has no reset; port A is applied last so it wins any collision.
  always_ff @(posedge clock) begin
    if (w_clr_we) r_mem[r_cnt] <= r_color;
    if (w_we_b)   r_mem[addr_b] <= din_b;
    if (w_we_a)   r_mem[addr_a] <= din_a;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dout_a   <= '0;
      r_dvalid_a <= 1'b0;
    end else begin
      r_dvalid_a <= re_a;
      if (re_a) begin
        if (!w_in_a)                     r_dout_a <= '0;
        else if (RDW_MODE == 1 && w_we_a) r_dout_a <= din_a;
        else                             r_dout_a <= r_mem[addr_a];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dout_b   <= '0;
      r_dvalid_b <= 1'b0;
    end else begin
      r_dvalid_b <= re_b;
      if (re_b) begin
        if (!w_in_b)                     r_dout_b <= '0;
        else if (RDW_MODE == 1 && w_we_b) r_dout_b <= din_b;
        else                             r_dout_b <= r_mem[addr_b];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (clear_req) begin
            r_state <= StClear;
            r_color <= clear_color;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StClear: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastAddr) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dout_a     = r_dout_a;
  assign dvalid_a   = r_dvalid_a;
  assign dout_b     = r_dout_b;
  assign dvalid_b   = r_dvalid_b;
  assign busy       = r_busy;
  assign clear_done = r_done;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed bench for vga_frame_buffer: one read-first and one write-first instance share
// all stimulus; expected values are hand-derived and tracked in a small memory model.
module tb_vga_frame_buffer;

  localparam int unsigned DW = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned DP = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          we_a = 1'b0, re_a = 1'b0, we_b = 1'b0, re_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;
  logic          clear_req = 1'b0;
  logic [DW-1:0] clear_color = '0;

  logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic          dvalid_a0, dvalid_b0, dvalid_a1, dvalid_b1;
  logic          busy0, busy1, done0, done1;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_mem [DP];

  always #5 clock = ~clock;

  vga_frame_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RDW_MODE(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .we_a(we_a), .re_a(re_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a0), .dvalid_a(dvalid_a0),
    .we_b(we_b), .re_b(re_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b0), .dvalid_b(dvalid_b0),
    .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy0), .clear_done(done0)
  );

  vga_frame_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RDW_MODE(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .we_a(we_a), .re_a(re_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a1), .dvalid_a(dvalid_a1),
    .we_b(we_b), .re_b(re_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b1), .dvalid_b(dvalid_b1),
    .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy1), .clear_done(done1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DP; i++) begin
      re_a   = 1'b1;
      addr_a = AW'(i);
      tick();
      check($sformatf("%s_a%0d", tag, i), {29'd0, dout_a0}, {29'd0, exp_mem[i]});
      check($sformatf("%s_v%0d", tag, i), {31'd0, dvalid_a0}, 32'd1);
    end
    re_a = 1'b0;
  endtask

  // Runs a full clear with a port write and a repeat request poked in mid-clear.
  task automatic run_clear(input string tag, input logic [DW-1:0] color);
    int busy_cycles = 0;
    int done_pulses = 0;
    int done_k = -1;
    clear_req   = 1'b1;
    clear_color = color;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy0) busy_cycles++;
      if (done0) begin
        done_pulses++;
        done_k = k;
      end
      if (k == 3) begin
        we_a = 1'b1; addr_a = 4'd0; din_a = 3'b011;
        clear_req = 1'b1; clear_color = 3'b111;
      end else begin
        we_a = 1'b0; clear_req = 1'b0;
      end
      tick();
    end
    check({tag, "_busy_cycles"}, busy_cycles, 32'd12);
    check({tag, "_done_pulses"}, done_pulses, 32'd1);
    check({tag, "_done_pos"}, done_k, 32'd12);
    check({tag, "_busy_end"}, {31'd0, busy0}, 32'd0);
    for (int i = 0; i < DP; i++) exp_mem[i] = color;
    read_all(tag);
  endtask

  initial begin
    int stray = 0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_dout_a", {29'd0, dout_a0}, 32'd0);
    check("rst_dout_b", {29'd0, dout_b0}, 32'd0);
    check("rst_dvalid_a", {31'd0, dvalid_a0}, 32'd0);
    check("rst_dvalid_b", {31'd0, dvalid_b0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);

    for (int i = 0; i < DP; i++) begin
      we_a = 1'b1; addr_a = AW'(i); din_a = DW'(i);
      exp_mem[i] = DW'(i);
      tick();
    end
    we_a = 1'b0;

    // Basic write on A, read on B
    we_a = 1'b1; addr_a = 4'd5; din_a = 3'b101; exp_mem[5] = 3'b101;
    tick();
    we_a = 1'b0; re_b = 1'b1; addr_b = 4'd5;
    tick();
    check("basic_dout_b", {29'd0, dout_b0}, 32'h5);
    check("basic_dvalid_b", {31'd0, dvalid_b0}, 32'd1);
    re_b = 1'b0;
    tick();
    check("hold_dvalid_b", {31'd0, dvalid_b0}, 32'd0);
    check("hold_dout_b", {29'd0, dout_b0}, 32'h5);

    // Both ports write addr 7: A wins
    we_a = 1'b1; addr_a = 4'd7; din_a = 3'b001;
    we_b = 1'b1; addr_b = 4'd7; din_b = 3'b110;
    tick();
    we_a = 1'b0; we_b = 1'b0; re_a = 1'b1; addr_a = 4'd7;
    tick();
    check("collide_a_wins", {29'd0, dout_a0}, 32'h1);
    re_a = 1'b0;

    // Cross-port read during write sees the old word in both modes
    we_a = 1'b1; addr_a = 4'd7; din_a = 3'b010;
    re_b = 1'b1; addr_b = 4'd7;
    tick();
    check("cross_old_m0", {29'd0, dout_b0}, 32'h1);
    check("cross_old_m1", {29'd0, dout_b1}, 32'h1);
    re_b = 1'b0;

    // Same-port read during write
    we_a = 1'b1; re_a = 1'b1; addr_a = 4'd7; din_a = 3'b011; exp_mem[7] = 3'b011;
    tick();
    check("rdw_read_first", {29'd0, dout_a0}, 32'h2);
    check("rdw_write_first", {29'd1, dout_a1} & 32'h7, 32'h3);
    we_a = 1'b0; re_a = 1'b0;

    // Out of range
    we_a = 1'b1; addr_a = 4'd13; din_a = 3'b111;
    tick();
    we_a = 1'b0; re_a = 1'b1; addr_a = 4'd13; re_b = 1'b1; addr_b = 4'd12;
    tick();
    check("oor_dout_a", {29'd0, dout_a0}, 32'd0);
    check("oor_dvalid_a", {31'd0, dvalid_a0}, 32'd1);
    check("oor_dout_b", {29'd0, dout_b0}, 32'd0);
    check("oor_dvalid_b", {31'd0, dvalid_b0}, 32'd1);
    re_a = 1'b0; re_b = 1'b0;
    read_all("oor_intact");

    run_clear("clr1", 3'b100);

    // Reset five edges after acceptance
    clear_req = 1'b1; clear_color = 3'b010;
    tick();
    clear_req = 1'b0;
    re_a = 1'b1; addr_a = 4'd9; re_b = 1'b1; addr_b = 4'd10;
    tick();
    check("mid_read_a", {29'd0, dout_a0}, 32'h4);
    check("mid_read_b", {29'd0, dout_b0}, 32'h4);
    check("mid_busy", {31'd0, busy0}, 32'd1);
    re_a = 1'b0; re_b = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mrst_busy", {31'd0, busy0}, 32'd0);
    check("mrst_done", {31'd0, done0}, 32'd0);
    check("mrst_dout_a", {29'd0, dout_a0}, 32'd0);
    check("mrst_dout_b", {29'd0, dout_b0}, 32'd0);
    check("mrst_dvalid_a", {31'd0, dvalid_a0}, 32'd0);
    check("mrst_dvalid_b", {31'd0, dvalid_b0}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (done0 || busy0) stray++;
      tick();
    end
    check("mrst_no_done", stray, 32'd0);
    for (int i = 0; i < 4; i++) exp_mem[i] = 3'b010;
    read_all("partial");

    run_clear("clr2", 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
